// File: rtl/gnss_ack_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gnss_ack_pkg
//  Description : Shared constants, scheduler state type and the GPS L1 C/A
//                G2 phase-select tap table for the acquisition search path.
//  Revision    : 1.0 - initial release
// ============================================================================
package gnss_ack_pkg;

  localparam int CA_LEN  = 1023;
  localparam int NUM_PRN = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_RUN       = 3'd2,
    ST_WAIT_CORR = 3'd3,
    ST_REPORT    = 3'd4
  } sched_state_t;

  // Returns {t0, t1}, both 1-based G2 stage numbers; unknown PRNs map to PRN 1.
  function automatic logic [7:0] prn_taps(input logic [5:0] prn);
    logic [7:0] taps;
    case (prn)
      6'd1:    taps = {4'd2, 4'd6};
      6'd2:    taps = {4'd3, 4'd7};
      6'd3:    taps = {4'd4, 4'd8};
      6'd4:    taps = {4'd5, 4'd9};
      6'd5:    taps = {4'd1, 4'd9};
      6'd6:    taps = {4'd2, 4'd10};
      6'd7:    taps = {4'd1, 4'd8};
      6'd8:    taps = {4'd2, 4'd9};
      6'd9:    taps = {4'd3, 4'd10};
      6'd10:   taps = {4'd2, 4'd3};
      6'd11:   taps = {4'd3, 4'd4};
      6'd12:   taps = {4'd5, 4'd6};
      6'd13:   taps = {4'd6, 4'd7};
      6'd14:   taps = {4'd7, 4'd8};
      6'd15:   taps = {4'd8, 4'd9};
      6'd16:   taps = {4'd9, 4'd10};
      6'd17:   taps = {4'd1, 4'd4};
      6'd18:   taps = {4'd2, 4'd5};
      6'd19:   taps = {4'd3, 4'd6};
      6'd20:   taps = {4'd4, 4'd7};
      6'd21:   taps = {4'd5, 4'd8};
      6'd22:   taps = {4'd6, 4'd9};
      6'd23:   taps = {4'd1, 4'd3};
      6'd24:   taps = {4'd4, 4'd6};
      6'd25:   taps = {4'd5, 4'd7};
      6'd26:   taps = {4'd6, 4'd8};
      6'd27:   taps = {4'd7, 4'd9};
      6'd28:   taps = {4'd8, 4'd10};
      6'd29:   taps = {4'd1, 4'd6};
      6'd30:   taps = {4'd2, 4'd7};
      6'd31:   taps = {4'd3, 4'd8};
      6'd32:   taps = {4'd4, 4'd9};
      default: taps = {4'd2, 4'd6};
    endcase
    return taps;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ca_prn_taps.sv
`default_nettype none
// ============================================================================
//  Module      : ca_prn_taps
//  Description : Combinational ROM mapping a PRN number to its G2 tap pair.
//  Revision    : 1.0 - initial release
// ============================================================================
module ca_prn_taps
  import gnss_ack_pkg::*;
(
  input  logic [5:0] prn,
  output logic [3:0] t0,
  output logic [3:0] t1
);

  // Table lookup; the package function is the single source of the taps.
  always_comb begin
    {t0, t1} = prn_taps(prn);
  end

endmodule
`default_nettype wire

// File: rtl/ca_search_sched.sv
`default_nettype none
// ============================================================================
//  Module      : ca_search_sched
//  Description : Acquisition search scheduler. Walks a PRN range, frames
//                1023-chip epochs for the C/A generator and correlator,
//                accumulates the per-epoch metric over a dwell and reports
//                one thresholded result per PRN over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module ca_search_sched
  import gnss_ack_pkg::*;
#(
  parameter int METRIC_W = 16,
  parameter int DWELL_W  = 4,
  parameter int ACC_W    = METRIC_W + DWELL_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [5:0]          prn_first,
  input  logic [5:0]          prn_last,
  input  logic [DWELL_W-1:0]  dwell,
  input  logic [ACC_W-1:0]    threshold,
  output logic                gen_rst,
  output logic [9:0]          g1_init,
  output logic [9:0]          g2_init,
  output logic [3:0]          t0,
  output logic [3:0]          t1,
  output logic [9:0]          chip_idx,
  output logic                epoch_start,
  output logic                epoch_end,
  input  logic                corr_valid,
  input  logic [METRIC_W-1:0] corr_metric,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [5:0]          res_prn,
  output logic [ACC_W-1:0]    res_acc,
  output logic                res_hit,
  output logic                busy,
  output logic                done,
  output logic                cfg_err
);

  localparam logic [9:0] c_chip_last = 10'(CA_LEN - 1);
  localparam logic [5:0] c_prn_max   = 6'(NUM_PRN);

  sched_state_t        r_state, w_state_nxt;
  logic [5:0]          r_cur_prn, r_prn_last, w_tap_prn;
  logic [DWELL_W-1:0]  r_dwell_max, r_ep_cnt;
  logic [ACC_W-1:0]    r_threshold, r_acc, w_acc_sat, r_res_acc;
  logic [ACC_W:0]      w_sum;
  logic [9:0]          r_chip;
  logic [3:0]          r_t0, r_t1, w_t0, w_t1;
  logic [5:0]          r_res_prn;
  logic                r_res_hit, r_done, r_cfg_err;
  logic                w_cfg_ok, w_last_epoch, w_last_prn;

  assign w_cfg_ok = (prn_first != 6'd0) && (prn_first <= c_prn_max) &&
                    (prn_last  != 6'd0) && (prn_last  <= c_prn_max) &&
                    (prn_first <= prn_last);
  assign w_last_epoch = ((r_ep_cnt + 1'b1) == r_dwell_max);
  assign w_last_prn   = (r_cur_prn == r_prn_last);

  // Saturating accumulate: one extra bit catches the carry, then clamp.
  assign w_sum     = {1'b0, r_acc} + (ACC_W+1)'(corr_metric);
  assign w_acc_sat = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];

  // PRN whose taps the next LOAD will present.
  assign w_tap_prn = (r_state == ST_IDLE)   ? prn_first :
                     (r_state == ST_REPORT) ? r_cur_prn + 6'd1 : r_cur_prn;

  ca_prn_taps u_taps (
    .prn (w_tap_prn),
    .t0  (w_t0),
    .t1  (w_t1)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:      if (start && w_cfg_ok) w_state_nxt = ST_LOAD;
      ST_LOAD:      w_state_nxt = ST_RUN;
      ST_RUN:       if (r_chip == c_chip_last) w_state_nxt = ST_WAIT_CORR;
      ST_WAIT_CORR: if (corr_valid) w_state_nxt = w_last_epoch ? ST_REPORT : ST_LOAD;
      ST_REPORT:    if (res_ready) w_state_nxt = w_last_prn ? ST_IDLE : ST_LOAD;
      default:      w_state_nxt = ST_IDLE;
    endcase
    if (abort) w_state_nxt = ST_IDLE;
  end

  // Configuration latch, chip counter, accumulator, taps and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_prn   <= '0;
      r_prn_last  <= '0;
      r_dwell_max <= DWELL_W'(1);
      r_threshold <= '0;
      r_acc       <= '0;
      r_ep_cnt    <= '0;
      r_chip      <= '0;
      r_t0        <= 4'd2;
      r_t1        <= 4'd6;
      r_res_prn   <= '0;
      r_res_acc   <= '0;
      r_res_hit   <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      if (w_state_nxt == ST_LOAD) begin
        r_t0 <= w_t0;
        r_t1 <= w_t1;
      end
      if (abort) begin
        // Leave the chip counter ready for a clean epoch on the next search.
        r_chip <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              if (w_cfg_ok) begin
                r_cur_prn   <= prn_first;
                r_prn_last  <= prn_last;
                r_dwell_max <= (dwell == '0) ? DWELL_W'(1) : dwell;
                r_threshold <= threshold;
                r_acc       <= '0;
                r_ep_cnt    <= '0;
              end else begin
                r_cfg_err <= 1'b1;
                r_done    <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            r_chip <= (r_chip == c_chip_last) ? '0 : r_chip + 10'd1;
          end
          ST_WAIT_CORR: begin
            if (corr_valid) begin
              r_acc    <= w_acc_sat;
              r_ep_cnt <= r_ep_cnt + 1'b1;
              if (w_last_epoch) begin
                r_res_prn <= r_cur_prn;
                r_res_acc <= w_acc_sat;
                r_res_hit <= (w_acc_sat >= r_threshold);
              end
            end
          end
          ST_REPORT: begin
            if (res_ready) begin
              if (w_last_prn) begin
                r_done <= 1'b1;
              end else begin
                r_cur_prn <= r_cur_prn + 6'd1;
                r_acc     <= '0;
                r_ep_cnt  <= '0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign gen_rst     = (r_state != ST_RUN);
  assign g1_init     = 10'h3FF;
  assign g2_init     = 10'h3FF;
  assign t0          = r_t0;
  assign t1          = r_t1;
  assign chip_idx    = r_chip;
  assign epoch_start = (r_state == ST_RUN) && (r_chip == 10'd0);
  assign epoch_end   = (r_state == ST_RUN) && (r_chip == c_chip_last);
  assign res_valid   = (r_state == ST_REPORT);
  assign res_prn     = r_res_prn;
  assign res_acc     = r_res_acc;
  assign res_hit     = r_res_hit;
  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign cfg_err     = r_cfg_err;

endmodule
`default_nettype wire

// File: doc/ca_search_sched.md
# ca_search_sched

Acquisition search scheduler for the GPS L1 C/A code generator (`CACODE`).
- Walks a programmed PRN range; per PRN loads the G2 phase-select taps and resets the generator at each epoch start.
- Frames 1023-chip epochs for the correlator and accumulates its per-epoch metric non-coherently over a programmable dwell.
- Returns one thresholded result per PRN over a valid/ready handshake.
- Sits between the acquisition control registers and the `CACODE` + correlator datapath.

## Interface
Parameters:
- `METRIC_W`, 16, width of the correlator metric
- `DWELL_W`, 4, width of the dwell (epochs per PRN) field
- `ACC_W`, `METRIC_W+DWELL_W`, accumulator/threshold width

Ports:
- `clk`  in  1  system clock; one clock domain
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin search; sampled only in IDLE
- `abort`  in  1  cancel search; any state
- `prn_first`  in  6  first PRN, 1..32
- `prn_last`  in  6  last PRN, 1..32, must be ≥ `prn_first`
- `dwell`  in  DWELL_W  epochs per PRN; 0 is treated as 1
- `threshold`  in  ACC_W  detection threshold
- `gen_rst`  out  1  to `CACODE.rst`
- `g1_init`, `g2_init`  out  10  constant `10'h3FF`
- `t0`, `t1`  out  4  G2 tap pair, 1-based, to `CACODE.T0/T1`
- `chip_idx`  out  10  chip index within the epoch, 0..1022
- `epoch_start`, `epoch_end`  out  1  single-cycle strobes at chip 0 and chip 1022
- `corr_valid`  in  1  correlator metric valid
- `corr_metric`  in  METRIC_W  per-epoch metric
- `res_valid`  out  1  result valid
- `res_ready`  in  1  result accepted
- `res_prn`  out  6  PRN of the result
- `res_acc`  out  ACC_W  accumulated metric
- `res_hit`  out  1  `res_acc >= threshold`
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at the end of the search
- `cfg_err`  out  1  one-cycle pulse when `start` carries an invalid range

## Operation
- States: IDLE, LOAD, RUN, WAIT_CORR, REPORT.
- IDLE:
  - `gen_rst=1`.
  - On `start` with a valid range, latch `prn_first`, `prn_last`, `dwell` and `threshold`. Set `cur_prn=prn_first`, `acc=0`, `ep_cnt=0`, then go to LOAD.
  - On `start` with an invalid range (0, >32, or first>last), pulse `cfg_err` and `done` on the next cycle and stay in IDLE.
- LOAD (one cycle):
  - `gen_rst=1`.
  - `t0/t1` come from the PRN tap table for `cur_prn`; they are registered and held stable until the next LOAD.
  - Go to RUN.
- RUN:
  - `gen_rst=0`; `chip_idx` counts 0..1022.
  - `epoch_start` is high at chip 0; `epoch_end` is high at chip 1022.
  - After chip 1022, go to WAIT_CORR.
- WAIT_CORR:
  - Wait for `corr_valid`, then `acc <= sat(acc + corr_metric)`, saturating at all-ones, and `ep_cnt++`.
  - If `ep_cnt+1 == max(dwell,1)`, go to REPORT; otherwise go to LOAD, which re-aligns the generator for the next epoch.
  - `corr_valid` is ignored in every other state.
- REPORT:
  - Hold `res_valid=1` with `res_prn`, `res_acc` and `res_hit` stable until `res_valid && res_ready`.
  - If `cur_prn == prn_last`, pulse `done` and go to IDLE.
  - Otherwise: `cur_prn++`, `acc=0`, `ep_cnt=0`, go to LOAD.
- Abort:
  - `abort` in any state forces IDLE on the next edge.
  - `res_valid` drops and no `done` pulse is produced.
  - `abort` has priority over `start` and `corr_valid` in the same cycle.
- `rst` mid-search has the same effect as `abort`, and all registers are reinitialised.

## Timing
- Reset values:
  - `gen_rst=1`, `t0=2`, `t1=6` (PRN 1), `g1_init=g2_init=10'h3FF`.
  - `chip_idx=0`.
  - `epoch_start`, `epoch_end`, `res_valid`, `res_hit`, `done`, `cfg_err`, `busy` all 0.
  - `res_prn=0`, `res_acc=0`; state IDLE.
- Per-epoch cycle sequence, with `start` sampled at edge k:
  - LOAD occupies cycle k+1.
  - `chip_idx=0` and `epoch_start` occur in cycle k+2; the `CACODE` chip is valid from that cycle.
  - `epoch_end` occurs in cycle k+1024; WAIT_CORR starts at k+1025.
- Epoch length is exactly 1023 RUN cycles; WAIT_CORR length is unbounded (no timeout).
- Results are registered: `res_valid` rises one cycle after the last `corr_valid` of the dwell.
- Back-to-back: with `res_ready` held high, REPORT lasts one cycle and the next LOAD follows immediately.

## Structure
- Package `gnss_ack_pkg`:
  - `CA_LEN=1023`, `NUM_PRN=32`.
  - State enum `sched_state_t`.
  - Tap-table function returning `{t0,t1}` for PRN 1..32: 1:(2,6), 2:(3,7), 3:(4,8), 4:(5,9), 5:(1,9), 6:(2,10), 7:(1,8), 8:(2,9), 9:(3,10), 10:(2,3), 11:(3,4), 12:(5,6), 13:(6,7), 14:(7,8), 15:(8,9), 16:(9,10), 17:(1,4), 18:(2,5), 19:(3,6), 20:(4,7), 21:(5,8), 22:(6,9), 23:(1,3), 24:(4,6), 25:(5,7), 26:(6,8), 27:(7,9), 28:(8,10), 29:(1,6), 30:(2,7), 31:(3,8), 32:(4,9).
- One sub-module, `ca_prn_taps`: a combinational ROM wrapping the table function.
- Scheduler FSM, counters and accumulator live in the top module.

## Test plan
- Search PRN 1..1, `dwell=1`, correlator answers `corr_metric=500` two cycles into WAIT_CORR, `threshold=400`:
  - In LOAD, `t0=2`, `t1=6`.
  - 1023 RUN cycles; `epoch_end` 1022 cycles after `epoch_start`.
  - One result: PRN 1, acc 500, hit=1.
  - `done` pulse.
  - `CACODE` `{g1,g2}` sequence matches the golden first 1023 chips.
- PRN 5..7, `dwell=3`, metric 100 per epoch, threshold 301:
  - Three results (PRNs 5, 6, 7), each acc=300, hit=0.
  - Nine LOAD pulses; taps (1,9), (2,10), (1,8).
- `res_ready` held low for 50 cycles in REPORT: outputs stay stable and no LOAD occurs; on release, next LOAD on the following cycle.
- Saturation with `METRIC_W=16`, `dwell=15`, metric `16'hFFFF`: acc=`15*65535`, no wrap; force acc near all-ones to check the saturating clamp.
- `abort` asserted during RUN chip 500, and separately during REPORT:
  - Next cycle IDLE, `gen_rst=1`, `res_valid=0`, no `done`.
  - A fresh `start` works normally.
- Invalid configurations: `start` with `prn_first=0`, with `prn_first=33`, and with `first=10, last=9` → `cfg_err` and `done` pulse, `busy` stays 0.
